// File: rtl/ram_pkg.sv
// ram_pkg: shared types and helpers for the dual-port RAM.
//   state_t        - clear engine states (STATE_CLEAR, STATE_READY)
//   data_width_ok  - elaboration check that a word is a whole number of bytes
//   byte_merge     - per-byte merge of a new word into an old one under a mask;
//                    used by both the write path and the collision bypass path
package ram_pkg;

    typedef enum logic {
        STATE_CLEAR = 1'b0,
        STATE_READY = 1'b1
    } state_t;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int unsigned MAX_DATA_WIDTH = 256;
    localparam int unsigned MAX_BYTES      = MAX_DATA_WIDTH / 8;

    function automatic bit data_width_ok(input int unsigned width);
        return (width != 0) && ((width % 8) == 0) && (width <= MAX_DATA_WIDTH);
    endfunction

    function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_BYTES-1:0]      mask
    );
        logic [MAX_DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
            if (mask[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/ram_dual_port_if.sv
// ram_dual_port_if: write port, read port and control bundle of the RAM.
//   Clear_i, WriteEnable_i, WriteAddress_i, WriteData_i, ByteEnable_i,
//   ReadEnable_i, ReadAddress_i  - requests toward the RAM
//   ReadData_o, ReadValid_o, Busy_o - responses from the RAM
//   master modport: the user of the RAM; slave modport: the RAM itself.
interface ram_dual_port_if #(
    parameter int unsigned ADDRESS_WIDTH = 4,
    parameter int unsigned DATA_WIDTH    = 8
);
    localparam int unsigned BYTE_COUNT = DATA_WIDTH / 8;

    logic                     Clear_i;
    logic                     WriteEnable_i;
    logic [ADDRESS_WIDTH-1:0] WriteAddress_i;
    logic [DATA_WIDTH-1:0]    WriteData_i;
    logic [BYTE_COUNT-1:0]    ByteEnable_i;
    logic                     ReadEnable_i;
    logic [ADDRESS_WIDTH-1:0] ReadAddress_i;
    logic [DATA_WIDTH-1:0]    ReadData_o;
    logic                     ReadValid_o;
    logic                     Busy_o;

    modport master (
        output Clear_i, WriteEnable_i, WriteAddress_i, WriteData_i, ByteEnable_i,
        output ReadEnable_i, ReadAddress_i,
        input  ReadData_o, ReadValid_o, Busy_o
    );

    modport slave (
        input  Clear_i, WriteEnable_i, WriteAddress_i, WriteData_i, ByteEnable_i,
        input  ReadEnable_i, ReadAddress_i,
        output ReadData_o, ReadValid_o, Busy_o
    );

endinterface

// File: rtl/ram_clear_fsm.sv
// ram_clear_fsm: sweeps every address once after reset or a clear request.
//   Clock, Reset          - rising-edge clock, synchronous active-high reset
//   Clear_i               - request to restart the sweep (honoured in READY)
//   clear_write_enable_c  - high while sweeping; owns the memory write port
//   clear_address         - address being cleared this cycle
//   busy                  - registered, high while sweeping
module ram_clear_fsm
    import ram_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 4
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Clear_i,
    output logic                     clear_write_enable_c,
    output logic [ADDRESS_WIDTH-1:0] clear_address,
    output logic                     busy
);

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] counter;

    // Sweep one word per cycle; the all-ones counter is the last word.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= STATE_CLEAR;
            counter <= '0;
            busy    <= 1'b1;
        end else begin
            case (state)
                STATE_CLEAR: begin
                    counter <= counter + 1'b1;
                    if (&counter) begin
                        state <= STATE_READY;
                        busy  <= 1'b0;
                    end
                end
                STATE_READY: begin
                    if (Clear_i) begin
                        state   <= STATE_CLEAR;
                        counter <= '0;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    state   <= STATE_CLEAR;
                    counter <= '0;
                    busy    <= 1'b1;
                end
            endcase
        end
    end

    assign clear_write_enable_c = (state == STATE_CLEAR);
    assign clear_address        = counter;

endmodule

// File: rtl/ram_dual_port.sv
// ram_dual_port: simple dual-port synchronous RAM with byte enables,
// registered read (latency 1, with valid strobe) and a built-in clear engine
// that writes CLEAR_VALUE to every word after reset or on Clear_i.
//   Clock, Reset - rising-edge clock, synchronous active-high reset
//   bus          - ram_dual_port_if slave: write port, read port, clear, busy
// Build option: define RAM_BYPASS_EN for write-first forwarding on a
// same-address read/write collision; default is read-first.
module ram_dual_port
    import ram_pkg::*;
#(
    parameter int unsigned          ADDRESS_WIDTH = 4,
    parameter int unsigned          DATA_WIDTH    = 8,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
    input  logic             Clock,
    input  logic             Reset,
    ram_dual_port_if.slave   bus
);

    localparam int unsigned DEPTH      = 2 ** ADDRESS_WIDTH;
    localparam int unsigned BYTE_COUNT = DATA_WIDTH / 8;

    if (!data_width_ok(DATA_WIDTH)) begin : g_width_check
        $error("ram_dual_port: DATA_WIDTH must be a non-zero multiple of 8");
    end

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic                     clear_write_enable_c;
    logic [ADDRESS_WIDTH-1:0] clear_address;
    logic                     busy;
    logic [DATA_WIDTH-1:0]    stored_word_c;
    logic [DATA_WIDTH-1:0]    read_word_c;

    ram_clear_fsm #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_clear_fsm (
        .Clock                (Clock),
        .Reset                (Reset),
        .Clear_i              (bus.Clear_i),
        .clear_write_enable_c (clear_write_enable_c),
        .clear_address        (clear_address),
        .busy                 (busy)
    );

    assign bus.Busy_o = busy;

    // Write port: clear sweep has priority; nothing is written on a reset edge.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            if (clear_write_enable_c) begin
                mem[clear_address] <= CLEAR_VALUE;
            end else if (bus.WriteEnable_i) begin
                mem[bus.WriteAddress_i] <= DATA_WIDTH'(byte_merge(
                    MAX_DATA_WIDTH'(mem[bus.WriteAddress_i]),
                    MAX_DATA_WIDTH'(bus.WriteData_i),
                    MAX_BYTES'(bus.ByteEnable_i)));
            end
        end
    end

    assign stored_word_c = mem[bus.ReadAddress_i];

`ifdef RAM_BYPASS_EN
    // Same-address collision returns the word as it will be after the write.
    always_comb begin
        read_word_c = stored_word_c;
        if (bus.WriteEnable_i && (bus.WriteAddress_i == bus.ReadAddress_i)) begin
            read_word_c = DATA_WIDTH'(byte_merge(
                MAX_DATA_WIDTH'(stored_word_c),
                MAX_DATA_WIDTH'(bus.WriteData_i),
                MAX_BYTES'(bus.ByteEnable_i)));
        end
    end
`else
    assign read_word_c = stored_word_c;
`endif

    // Read register: data holds unless a read is accepted outside a sweep.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            bus.ReadData_o  <= '0;
            bus.ReadValid_o <= 1'b0;
        end else if (clear_write_enable_c || !bus.ReadEnable_i) begin
            bus.ReadValid_o <= 1'b0;
        end else begin
            bus.ReadData_o  <= read_word_c;
            bus.ReadValid_o <= 1'b1;
        end
    end

    logic unused_bytes;
    assign unused_bytes = (BYTE_COUNT == 0);

endmodule

// File: tb/tb_ram_dual_port.sv
// tb_ram_dual_port: directed and randomized checks of ram_dual_port against
// a word-array reference model (ADDRESS_WIDTH=4, DATA_WIDTH=16).
module tb_ram_dual_port;
    import ram_pkg::*;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 16;
`ifdef RAM_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic Clock;
    logic Reset;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    ram_dual_port_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    ram_dual_port_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus_a5 ();

    ram_dual_port #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_VALUE(16'h0000)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    ram_dual_port #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_VALUE(16'hA5A5)) dut_a5 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus_a5)
    );

    int          tests = 0;
    int          fails = 0;
    logic [15:0] model [DEPTH];
    logic [15:0] exp_data;
    int          busy_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model of a byte-masked update: each enabled byte comes from the new word.
    function automatic logic [15:0] merged(input logic [15:0] old_w, input logic [15:0] new_w,
                                           input logic [1:0] be);
        logic [15:0] r;
        r = old_w;
        if (be[0]) r = (r & 16'hFF00) | (new_w & 16'h00FF);
        if (be[1]) r = (r & 16'h00FF) | (new_w & 16'hFF00);
        return r;
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        bus.Clear_i        = 1'b0;
        bus.WriteEnable_i  = 1'b0;
        bus.WriteAddress_i = '0;
        bus.WriteData_i    = '0;
        bus.ByteEnable_i   = '0;
        bus.ReadEnable_i   = 1'b0;
        bus.ReadAddress_i  = '0;
    endtask

    // One READY-state cycle: drive, predict from the model, clock, compare.
    task automatic step(input string tag, input bit we, input logic [3:0] wa,
                        input logic [15:0] wd, input logic [1:0] be,
                        input bit re, input logic [3:0] ra);
        bus.WriteEnable_i  = we;
        bus.WriteAddress_i = wa;
        bus.WriteData_i    = wd;
        bus.ByteEnable_i   = be;
        bus.ReadEnable_i   = re;
        bus.ReadAddress_i  = ra;
        if (re) begin
            if (BYPASS && we && (wa == ra)) exp_data = merged(model[ra], wd, be);
            else                            exp_data = model[ra];
        end
        if (we) model[wa] = merged(model[wa], wd, be);
        tick();
        check({tag, "_valid"}, 32'(bus.ReadValid_o), 32'(re));
        check({tag, "_data"}, 32'(bus.ReadData_o), 32'(exp_data));
    endtask

    // Counts busy cycles while hammering the ports; all requests must be ignored.
    task automatic count_busy(input string tag);
        int guard;
        busy_count = 0;
        guard      = 0;
        while ((bus.Busy_o === 1'b1) && (guard < 40)) begin
            busy_count++;
            guard++;
            bus.WriteEnable_i  = 1'b1;
            bus.WriteAddress_i = 4'($urandom_range(0, 15));
            bus.WriteData_i    = 16'hFFFF;
            bus.ByteEnable_i   = 2'b11;
            bus.ReadEnable_i   = 1'b1;
            bus.ReadAddress_i  = 4'($urandom_range(0, 15));
            tick();
            check({tag, "_busy_valid"}, 32'(bus.ReadValid_o), 32'd0);
            check({tag, "_busy_hold"}, 32'(bus.ReadData_o), 32'(exp_data));
        end
        idle();
        check({tag, "_busy_cycles"}, 32'(busy_count), 32'd16);
        for (int i = 0; i < int'(DEPTH); i++) model[i] = 16'h0000;
    endtask

    initial begin
        idle();
        bus_a5.Clear_i        = 1'b0;
        bus_a5.WriteEnable_i  = 1'b0;
        bus_a5.WriteAddress_i = '0;
        bus_a5.WriteData_i    = '0;
        bus_a5.ByteEnable_i   = '0;
        bus_a5.ReadEnable_i   = 1'b0;
        bus_a5.ReadAddress_i  = '0;
        exp_data = 16'h0000;

        // 1. Reset, clear sweep length, read back cleared words.
        Reset = 1'b1;
        tick();
        tick();
        check("rst_busy", 32'(bus.Busy_o), 32'd1);
        check("rst_valid", 32'(bus.ReadValid_o), 32'd0);
        check("rst_data", 32'(bus.ReadData_o), 32'd0);
        check("rst_a5_busy", 32'(bus_a5.Busy_o), 32'd1);
        Reset = 1'b0;
        count_busy("t1");
        check("t1_a5_busy_done", 32'(bus_a5.Busy_o), 32'd0);
        for (int i = 0; i < int'(DEPTH); i++) begin
            bus_a5.ReadEnable_i  = 1'b1;
            bus_a5.ReadAddress_i = 4'(i);
            step("t1_rd", 1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'(i));
            check("t1_a5_valid", 32'(bus_a5.ReadValid_o), 32'd1);
            check("t1_a5_data", 32'(bus_a5.ReadData_o), 32'hA5A5);
        end
        bus_a5.ReadEnable_i = 1'b0;

        // 2. Full-word write then read; valid lasts one cycle.
        step("t2_wr", 1'b1, 4'd3, 16'hBEEF, 2'b11, 1'b0, 4'd0);
        step("t2_rd", 1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd3);
        check("t2_const", 32'(bus.ReadData_o), 32'hBEEF);
        step("t2_idle", 1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0);

        // 3. Partial and empty byte masks.
        step("t3_wr_lo", 1'b1, 4'd3, 16'h1234, 2'b01, 1'b0, 4'd0);
        step("t3_rd", 1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd3);
        check("t3_const", 32'(bus.ReadData_o), 32'hBE34);
        step("t3_wr_none", 1'b1, 4'd3, 16'hFFFF, 2'b00, 1'b0, 4'd0);
        step("t3_rd2", 1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd3);
        check("t3_const2", 32'(bus.ReadData_o), 32'hBE34);

        // 4. Same-address collision.
        step("t4_coll", 1'b1, 4'd5, 16'hAAAA, 2'b10, 1'b1, 4'd5);
        check("t4_const", 32'(bus.ReadData_o), BYPASS ? 32'hAA00 : 32'h0000);
        step("t4_rd", 1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd5);
        check("t4_const2", 32'(bus.ReadData_o), 32'hAA00);

        // 5. Clear request: same-cycle access completes, then sweep ignores ports.
        bus.Clear_i = 1'b1;
        step("t5_req", 1'b1, 4'd7, 16'h7777, 2'b11, 1'b1, 4'd3);
        bus.Clear_i = 1'b0;
        check("t5_busy_rise", 32'(bus.Busy_o), 32'd1);
        count_busy("t5");
        step("t5_rd3", 1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd3);
        check("t5_const", 32'(bus.ReadData_o), 32'h0000);
        step("t5_rd7", 1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd7);

        // 6. Reset in the middle of a sweep restarts it.
        step("t6_wr", 1'b1, 4'd9, 16'h9999, 2'b11, 1'b0, 4'd0);
        bus.Clear_i = 1'b1;
        step("t6_req", 1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0);
        bus.Clear_i = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("t6_mid_busy", 32'(bus.Busy_o), 32'd1);
        Reset = 1'b1;
        tick();
        Reset    = 1'b0;
        exp_data = 16'h0000;
        check("t6_rst_data", 32'(bus.ReadData_o), 32'd0);
        count_busy("t6");
        for (int i = 0; i < int'(DEPTH); i++) begin
            step("t6_rd", 1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'(i));
        end

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            step("rnd", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 16'($urandom), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_dual_port.md
Name: ram_dual_port

Overview:
Simple dual-port synchronous RAM: one write port and one independent read port.
- Per-byte write enables; registered read with a valid strobe.
- Built-in clear engine fills every word with CLEAR_VALUE after reset or on request.
- General-purpose buffer/scratchpad memory for FIFOs, frame buffers and register files; parametrised successor of the single-port RAM.

Parameters:
ADDRESS_WIDTH, 4, address bits; DEPTH = 2**ADDRESS_WIDTH words
DATA_WIDTH, 8, word width in bits; must be a multiple of 8 (elaboration error otherwise)
CLEAR_VALUE, 0, word written to every location by the clear engine

Ports:
Clock  input  1  single clock, all logic on rising edge
Reset  input  1  synchronous, active-high reset
Clear_i  input  1  single-cycle request to re-clear whole memory
WriteEnable_i  input  1  write strobe
WriteAddress_i  input  ADDRESS_WIDTH  write address
WriteData_i  input  DATA_WIDTH  write data
ByteEnable_i  input  DATA_WIDTH/8  per-byte write mask; bit n covers bits [8n+7:8n]
ReadEnable_i  input  1  read strobe
ReadAddress_i  input  ADDRESS_WIDTH  read address
ReadData_o  output  DATA_WIDTH  registered read data
ReadValid_o  output  1  high one cycle after an accepted read
Busy_o  output  1  high while clear engine runs

Behaviour:
- States: CLEAR, READY. Clear counter is ADDRESS_WIDTH bits.
- Reset high (at an edge):
  - state <= CLEAR, counter <= 0.
  - ReadData_o <= 0, ReadValid_o <= 0, Busy_o <= 1.
  - No memory write.
  - Applies at any time, including mid-clear: the clear restarts from address 0.
- CLEAR (Reset low):
  - Each edge writes CLEAR_VALUE to Memory[counter], then counter + 1.
  - When counter == DEPTH-1: write the last word, state <= READY, Busy_o <= 0.
  - Busy_o is therefore high for exactly DEPTH cycles after Reset release.
  - WriteEnable_i, ReadEnable_i and Clear_i are ignored. ReadValid_o stays 0 and ReadData_o holds its value.
- READY:
  - Write: WriteEnable_i=1 updates only the bytes of Memory[WriteAddress_i] whose ByteEnable_i bit is 1. ByteEnable_i=0 leaves the word unchanged.
  - Read: ReadEnable_i=1 at edge N gives ReadData_o = Memory[ReadAddress_i] and ReadValid_o=1 after edge N (latency 1).
  - ReadEnable_i=0: ReadValid_o <= 0 and ReadData_o holds its last value.
  - Back-to-back reads give one word per cycle.
  - Clear_i=1: state <= CLEAR, counter <= 0, Busy_o <= 1 on the next edge. Any write or read in that same cycle is still performed and completes normally.
- Simultaneous read and write to the same address: read-first. ReadData_o returns the pre-write word (see RAM_BYPASS_EN).
- Simultaneous read and write to different addresses are independent.
- Memory contents are undefined before the first clear completes; the bench must not rely on them.

Optional Feature:
RAM_BYPASS_EN
- Defined: write-first forwarding on same-address collision. ReadData_o = for each byte, WriteData_i byte if its ByteEnable_i bit is 1, else the old memory byte.
- Undefined: read-first. Old word returned; no forwarding logic synthesised.
- All other timing is identical in both builds.

Decomposition:
- Package ram_pkg:
  - state encoding localparams (STATE_CLEAR, STATE_READY)
  - the DATA_WIDTH % 8 check macro/function
  - byte-merge function (old, new, mask) -> merged word, shared by the write path and the bypass path
- Sub-module ram_clear_fsm:
  - holds state, counter, Busy_o
  - outputs ClearWriteEnable and ClearAddress to the top-level write mux (clear write takes priority)
  - top level holds the memory array and the read register

Test Plan (ADDRESS_WIDTH=4, DATA_WIDTH=16, CLEAR_VALUE=16'h0000 unless noted):
1. Reset high 2 cycles, then low -> Busy_o=1 for exactly 16 cycles. Then reading addr 0..15 back-to-back gives 0x0000 each with ReadValid_o=1 on 16 consecutive cycles. Repeat with CLEAR_VALUE=16'hA5A5 -> all reads 0xA5A5.
2. Write addr 3 = 0xBEEF with BE=2'b11, then read addr 3 -> next cycle ReadData_o=0xBEEF, ReadValid_o=1 for one cycle only.
3. Write addr 3 = 0x1234 with BE=2'b01, then read addr 3 -> 0xBE34. Write BE=2'b00 -> still 0xBE34.
4. Addr 5 holds 0x0000; same cycle write 0xAAAA with BE=2'b10 and read addr 5 -> 0x0000 without RAM_BYPASS_EN, 0xAA00 with it. A subsequent read gives 0xAA00 in both builds.
5. Clear_i pulse in READY -> Busy_o=1 for 16 cycles. Writes and reads issued during it are ignored (ReadValid_o=0). Afterwards addr 3 reads 0x0000.
6. Reset asserted when clear counter=7 -> after release Busy_o high for 16 cycles, clear restarts at 0, and all words read 0x0000.
